// File: rtl/seg_scan_display_pkg.sv
// seg_scan_display_pkg: digit count and active-low 7-segment patterns shared by the scan display.
// Pattern bit order is [6:0] = g..a; a 0 lights the segment.
package seg_scan_display_pkg;
    localparam int NUM_DIGITS = 6;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/seg_scan_display_bcd_to_seg.sv
// bcd_to_seg: one BCD nibble to an active-low 7-segment pattern; non-decimal nibbles show "E".
module bcd_to_seg
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);
    always_comb begin
        case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_E;
        endcase
    end
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: six-digit multiplexed 7-segment driver with frame-aligned updates,
// leading-zero blanking, fixed decimal point and a staleness timeout that shows dashes.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int SCAN_CYC    = 50_000,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int DP_POS      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_vld,
    input  logic [23:0] bcd_data,
    output logic [5:0]  sel,
    output logic [7:0]  seg,
    output logic        stale,
    output logic        err
);
    localparam int SW = SCAN_CYC > 1 ? $clog2(SCAN_CYC) : 1;
    localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYC - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    DP_IDX    = 3'(DP_POS);
    localparam logic [2:0]    LAST_IDX  = 3'(NUM_DIGITS - 1);

    logic [SW-1:0] cnt, cnt_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [23:0]   pend, disp, disp_nxt;
    logic          pend_vld, disp_vld, disp_vld_nxt, stale_nxt;
    logic          tc, wrap, dash, blank, bad;
    logic [5:0]    lz;
    logic [3:0]    nib;
    logic [6:0]    pat;
    logic [7:0]    seg_nxt;

    // Outputs are registered from next-state values so sel and seg move together
    // with the digit index and the frame transfer on the same edge.
    always_comb begin
        tc           = cnt == SCAN_LAST;
        wrap         = tc && idx == LAST_IDX;
        cnt_nxt      = tc ? '0 : cnt + 1'b1;
        idx_nxt      = wrap ? 3'd0 : tc ? idx + 3'd1 : idx;
        tcnt_nxt     = data_vld ? '0 : tcnt == TO_LAST ? tcnt : tcnt + 1'b1;
        stale_nxt    = !data_vld && (stale || tcnt_nxt == TO_LAST);
        disp_nxt     = wrap ? pend : disp;
        disp_vld_nxt = !stale && (wrap ? pend_vld : disp_vld);
        dash         = stale_nxt || !disp_vld_nxt;
        nib          = disp_nxt[{idx_nxt, 2'b00} +: 4];
        lz[NUM_DIGITS-1] = disp_nxt[23:20] == 4'd0;
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            lz[i] = lz[i+1] && disp_nxt[i*4 +: 4] == 4'd0;
        bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            bad = bad || disp_nxt[i*4 +: 4] > 4'd9;
        blank   = idx_nxt > DP_IDX && lz[idx_nxt];
        seg_nxt = dash ? {1'b1, SEG_DASH} : blank ? {1'b1, SEG_BLANK} : {idx_nxt != DP_IDX, pat};
    end

    bcd_to_seg u_dec (
        .nibble  (nib),
        .pattern (pat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            tcnt     <= '0;
            idx      <= 3'd0;
            pend     <= '0;
            pend_vld <= 1'b0;
            disp     <= '0;
            disp_vld <= 1'b0;
            stale    <= 1'b1;
            sel      <= 6'h3F;
            seg      <= 8'hFF;
            err      <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            tcnt     <= tcnt_nxt;
            idx      <= idx_nxt;
            pend     <= data_vld ? bcd_data : pend;
            pend_vld <= data_vld || (pend_vld && !stale);
            disp     <= disp_nxt;
            disp_vld <= disp_vld_nxt;
            stale    <= stale_nxt;
            sel      <= ~(6'd1 << idx_nxt);
            seg      <= seg_nxt;
            err      <= !dash && bad;
        end
    end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed table of display values plus hand sequences for wrap,
// back-to-back, timeout, stale recovery and asynchronous reset.
module tb_seg_scan_display;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_vld;
    logic [23:0] bcd_data;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic        stale;
    logic        err;
    int          checks = 0;
    int          failures = 0;
    int          k = 0;
    int          pk = 0;

    typedef struct {
        logic [23:0]     bcd;
        logic [5:0][7:0] exp;
        logic            err;
    } vec_t;
    vec_t tbl [8];

    seg_scan_display #(.SCAN_CYC(4), .TIMEOUT_CYC(100), .DP_POS(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_vld (data_vld),
        .bcd_data (bcd_data),
        .sel      (sel),
        .seg      (seg),
        .stale    (stale),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic pulse(input logic [23:0] v);
        data_vld = 1'b1;
        bcd_data = v;
        tick();
        data_vld = 1'b0;
        pk = k;
    endtask

    task automatic goto_frame_start();
        for (int i = 0; i < 24 && k % 24 != 0; i++) tick();
    endtask

    // Call right after a wrap edge; walks all six digits of one frame.
    task automatic check_frame(input string tag, input logic [5:0][7:0] e, input logic exp_err);
        logic [5:0] es;
        for (int d = 0; d < 6; d++) begin
            es = ~(6'b000001 << d);
            chk($sformatf("%s_sel%0d", tag, d), sel, es);
            chk($sformatf("%s_seg%0d", tag, d), seg, e[d]);
            chk($sformatf("%s_err%0d", tag, d), err, exp_err);
            chk($sformatf("%s_stale%0d", tag, d), stale, 1'b0);
            repeat (4) tick();
        end
    endtask

    initial begin
        logic [5:0] es;
        tbl[0] = '{24'h001234, {8'hFF, 8'hFF, 8'h79, 8'hA4, 8'hB0, 8'h99}, 1'b0};
        tbl[1] = '{24'h000005, {8'hFF, 8'hFF, 8'h40, 8'hC0, 8'hC0, 8'h92}, 1'b0};
        tbl[2] = '{24'h00A000, {8'hFF, 8'hFF, 8'h06, 8'hC0, 8'hC0, 8'hC0}, 1'b1};
        tbl[3] = '{24'h000100, {8'hFF, 8'hFF, 8'h40, 8'hF9, 8'hC0, 8'hC0}, 1'b0};
        tbl[4] = '{24'h987650, {8'h90, 8'h80, 8'h78, 8'h82, 8'h92, 8'hC0}, 1'b0};
        tbl[5] = '{24'h050000, {8'hFF, 8'h92, 8'h40, 8'hC0, 8'hC0, 8'hC0}, 1'b0};
        tbl[6] = '{24'hF00000, {8'h86, 8'hC0, 8'h40, 8'hC0, 8'hC0, 8'hC0}, 1'b1};
        tbl[7] = '{24'h000000, {8'hFF, 8'hFF, 8'h40, 8'hC0, 8'hC0, 8'hC0}, 1'b0};

        rst_n = 1'b0;
        data_vld = 1'b0;
        bcd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", sel, 6'h3F);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_stale", stale, 1'b1);
        chk("rst_err", err, 1'b0);

        rst_n = 1'b1;
        k = 0;
        for (int n = 1; n <= 24; n++) begin
            tick();
            es = ~(6'b000001 << ((k / 4) % 6));
            chk($sformatf("idle_sel_k%0d", k), sel, es);
            chk($sformatf("idle_seg_k%0d", k), seg, 8'hBF);
            chk($sformatf("idle_stale_k%0d", k), stale, 1'b1);
        end

        for (int v = 0; v < 8; v++) begin
            tick();
            pulse(tbl[v].bcd);
            goto_frame_start();
            check_frame($sformatf("vec%0d", v), tbl[v].exp, tbl[v].err);
        end

        tick();
        pulse(24'h000222);
        for (int i = 0; i < 24 && (k + 1) % 24 != 0; i++) tick();
        pulse(24'h000111);
        check_frame("wrap_old", {8'hFF, 8'hFF, 8'h40, 8'hA4, 8'hA4, 8'hA4}, 1'b0);
        check_frame("wrap_new", {8'hFF, 8'hFF, 8'h40, 8'hF9, 8'hF9, 8'hF9}, 1'b0);

        tick();
        pulse(24'h000333);
        pulse(24'h000444);
        goto_frame_start();
        check_frame("b2b", {8'hFF, 8'hFF, 8'h40, 8'h99, 8'h99, 8'h99}, 1'b0);

        tick();
        pulse(24'hF00000);
        goto_frame_start();
        chk("to_err_before", err, 1'b1);
        for (int i = 0; i < 200 && k < pk + 98; i++) tick();
        chk("to_stale_98", stale, 1'b0);
        tick();
        chk("to_stale_99", stale, 1'b1);
        chk("to_seg_dash", seg, 8'hBF);
        chk("to_err_clr", err, 1'b0);

        repeat (5) tick();
        if ((k + 1) % 24 == 0) tick();
        pulse(24'h000777);
        chk("rec_stale", stale, 1'b0);
        chk("rec_seg_dash", seg, 8'hBF);
        for (int i = 0; i < 24 && (k + 1) % 24 != 0; i++) tick();
        chk("rec_seg_prewrap", seg, 8'hBF);
        tick();
        check_frame("rec", {8'hFF, 8'hFF, 8'h40, 8'hF8, 8'hF8, 8'hF8}, 1'b0);

        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", sel, 6'h3F);
        chk("mid_rst_seg", seg, 8'hFF);
        chk("mid_rst_stale", stale, 1'b1);
        chk("mid_rst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        tick();
        chk("rel_sel", sel, 6'b111110);
        chk("rel_seg", seg, 8'hBF);
        chk("rel_stale", stale, 1'b1);
        repeat (3) tick();
        chk("rel_sel_d1", sel, 6'b111101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
